// File: rtl/apb_seq_pkg.sv
// rtl/apb_seq_pkg.sv - shared state encoding and default sizes for the APB master sequencer
package apb_seq_pkg;

    localparam int ADDR_W_DEF         = 8;
    localparam int DATA_W_DEF         = 8;
    localparam int TIMEOUT_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/apb_watchdog.sv
// rtl/apb_watchdog.sv - ACCESS-phase wait counter, instantiated only when APB_TIMEOUT_EN is defined
module apb_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The wait cycle that would bring the count to LIMIT is the last one tolerated.
    assign expired = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/apb_master_sequencer.sv
// rtl/apb_master_sequencer.sv - single-transfer APB3 master that stalls the core until completion
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_sequencer
    import apb_seq_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              apb_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              continue_flag,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_e            state_q, state_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              timeout_hit;

`ifdef APB_TIMEOUT_EN
    apb_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q == ST_SETUP),
        .count  ((state_q == ST_ACCESS) && !pready),
        .expired(timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SETUP;
                    pwrite_d = apb_write;
                    paddr_d  = addr;
                    pwdata_d = wdata;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                // A ready arriving on the limit cycle completes normally.
                if (pready) begin
                    state_d = ST_DONE;
                    err_d   = pslverr;
                    if (!pwrite_q) begin
                        rdata_d = prdata;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                    if (!pwrite_q) begin
                        rdata_d = '0;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Bus strobes decode straight from the state flop so an async reset drops them at once.
    assign psel          = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign penable       = (state_q == ST_ACCESS);
    assign done          = (state_q == ST_DONE);
    assign continue_flag = !(psel || ((state_q == ST_IDLE) && start));
    assign pwrite        = pwrite_q;
    assign paddr         = paddr_q;
    assign pwdata        = pwdata_q;
    assign rdata         = rdata_q;
    assign err           = err_q;

endmodule

// File: tb/tb_apb_master_sequencer.sv
// tb/tb_apb_master_sequencer.sv - directed self-checking bench for apb_master_sequencer
module tb_apb_master_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       apb_write = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       continue_flag;
    logic       done;
    logic [7:0] rdata;
    logic       err;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata = 8'h00;
    logic       pready = 1'b1;
    logic       pslverr = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    apb_master_sequencer #(
        .ADDR_W(8),
        .DATA_W(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .apb_write    (apb_write),
        .addr         (addr),
        .wdata        (wdata),
        .continue_flag(continue_flag),
        .done         (done),
        .rdata        (rdata),
        .err          (err),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .prdata       (prdata),
        .pready       (pready),
        .pslverr      (pslverr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({psel, penable, pwrite, done, err} !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_ctrl: psel/penable/pwrite/done/err got %b expected 00000", {psel, penable, pwrite, done, err});
        end
        vectors++;
        if ({paddr, pwdata, rdata} !== 24'h000000) begin
            miscompares++;
            $display("FAIL reset_data: paddr/pwdata/rdata got %h expected 000000", {paddr, pwdata, rdata});
        end
        vectors++;
        if (continue_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_continue: got %b expected 1", continue_flag);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_zero_wait();
        start = 1'b1; apb_write = 1'b1; addr = 8'h10; wdata = 8'hA5; pready = 1'b1; pslverr = 1'b0;
        #1;
        vectors++;
        if ({continue_flag, psel} !== 2'b00) begin
            miscompares++;
            $display("FAIL wr_cycle_n: continue_flag/psel got %b expected 00", {continue_flag, psel});
        end
        tick();
        start = 1'b0;
        vectors++;
        if ({psel, penable, pwrite, continue_flag, done} !== 5'b10100 || paddr !== 8'h10 || pwdata !== 8'hA5) begin
            miscompares++;
            $display("FAIL wr_setup: ctrl got %b paddr %h pwdata %h expected 10100 10 a5", {psel, penable, pwrite, continue_flag, done}, paddr, pwdata);
        end
        tick();
        vectors++;
        if ({psel, penable, continue_flag, done} !== 4'b1100) begin
            miscompares++;
            $display("FAIL wr_access: psel/penable/continue/done got %b expected 1100", {psel, penable, continue_flag, done});
        end
        tick();
        vectors++;
        if ({done, err, psel, penable, continue_flag} !== 5'b10001 || paddr !== 8'h10) begin
            miscompares++;
            $display("FAIL wr_done: done/err/psel/penable/continue got %b paddr %h expected 10001 10", {done, err, psel, penable, continue_flag}, paddr);
        end
        tick();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_done_pulse: done got %b expected 0", done);
        end
    endtask

    task automatic test_read_wait_states();
        int low_cycles = 0;
        int done_cyc = -1;
        start = 1'b1; apb_write = 1'b0; addr = 8'h04; prdata = 8'h3C; pready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c == 1) start = 1'b0;
            pready = (c == 5);
            #1;
            if (!continue_flag) low_cycles++;
            if (done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (done_cyc != 6) begin
            miscompares++;
            $display("FAIL rd_wait_done_cycle: got N+%0d expected N+6", done_cyc);
        end
        vectors++;
        if (low_cycles != 6) begin
            miscompares++;
            $display("FAIL rd_wait_stall: continue_flag low %0d cycles expected 6", low_cycles);
        end
        vectors++;
        if (rdata !== 8'h3C || err !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_wait_data: rdata %h err %b expected 3c 0", rdata, err);
        end
        pready = 1'b1;
        tick();
    endtask

    task automatic test_slave_error();
        start = 1'b1; apb_write = 1'b0; addr = 8'h20; prdata = 8'h77; pready = 1'b1; pslverr = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        vectors++;
        if ({done, err} !== 2'b11 || rdata !== 8'h77) begin
            miscompares++;
            $display("FAIL slverr_done: done/err got %b rdata %h expected 11 77", {done, err}, rdata);
        end
        tick();
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL slverr_hold: err got %b expected 1", err);
        end
        pslverr = 1'b0;
        start = 1'b1; apb_write = 1'b1; addr = 8'h21; wdata = 8'h5A; prdata = 8'hEE;
        tick();
        start = 1'b0;
        tick();
        tick();
        vectors++;
        if ({done, err} !== 2'b10 || rdata !== 8'h77) begin
            miscompares++;
            $display("FAIL slverr_clear: done/err got %b rdata %h expected 10 77", {done, err}, rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_access();
        int saw_done = 0;
        start = 1'b1; apb_write = 1'b0; addr = 8'h08; pready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        vectors++;
        if ({psel, penable} !== 2'b11) begin
            miscompares++;
            $display("FAIL rst_mid_pre: psel/penable got %b expected 11", {psel, penable});
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({psel, penable, continue_flag} !== 3'b001) begin
            miscompares++;
            $display("FAIL rst_mid_async: psel/penable/continue got %b expected 001", {psel, penable, continue_flag});
        end
        for (int c = 0; c < 4; c++) begin
            if (c == 2) reset = 1'b0;
            tick();
            if (done) saw_done++;
        end
        vectors++;
        if (saw_done != 0 || paddr !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_mid_nodone: done pulses %0d paddr %h expected 0 00", saw_done, paddr);
        end
        start = 1'b1; apb_write = 1'b1; addr = 8'h33; wdata = 8'hC3; pready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        vectors++;
        if (done !== 1'b1 || paddr !== 8'h33 || pwdata !== 8'hC3) begin
            miscompares++;
            $display("FAIL rst_mid_recover: done %b paddr %h pwdata %h expected 1 33 c3", done, paddr, pwdata);
        end
        tick();
    endtask

    task automatic test_ignored_start();
        int setups = 0;
        int dones = 0;
        apb_write = 1'b1; addr = 8'h40; wdata = 8'h11; pready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            start = (c == 0) || (c == 1) || (c == 3);
            if (c == 1) addr = 8'h41;
            #1;
            if (psel && !penable) setups++;
            if (done) dones++;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        vectors++;
        if (setups != 1 || dones != 1) begin
            miscompares++;
            $display("FAIL ignored_start_count: setups %0d dones %0d expected 1 1", setups, dones);
        end
        vectors++;
        if (paddr !== 8'h40) begin
            miscompares++;
            $display("FAIL ignored_start_addr: paddr got %h expected 40", paddr);
        end
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        int acc = 0;
        int got = 0;
        apb_write = 1'b0; addr = 8'h50; prdata = 8'h99; pready = 1'b0; pslverr = 1'b0;
        for (int c = 0; c < 60; c++) begin
            start = (c == 0);
            #1;
            if (psel && penable) acc++;
            if (done) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (got != 1 || acc != 16) begin
            miscompares++;
            $display("FAIL timeout_len: done %0d access cycles %0d expected 1 16", got, acc);
        end
        vectors++;
        if (err !== 1'b1 || rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL timeout_status: err %b rdata %h expected 1 00", err, rdata);
        end
        tick();
        acc = 0;
        got = 0;
        prdata = 8'h5E;
        for (int c = 0; c < 60; c++) begin
            start = (c == 0);
            pready = (c == 17);
            #1;
            if (psel && penable) acc++;
            if (done) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (got != 1 || acc != 16 || err !== 1'b0 || rdata !== 8'h5E) begin
            miscompares++;
            $display("FAIL timeout_ready_wins: done %0d acc %0d err %b rdata %h expected 1 16 0 5e", got, acc, err, rdata);
        end
        pready = 1'b1;
        tick();
    endtask
`else
    task automatic test_timeout();
        apb_write = 1'b0; addr = 8'h50; pready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (100) tick();
        vectors++;
        if ({psel, penable, done, continue_flag} !== 4'b1100) begin
            miscompares++;
            $display("FAIL no_timeout_wait: psel/penable/done/continue got %b expected 1100", {psel, penable, done, continue_flag});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pready = 1'b1;
        tick();
        vectors++;
        if ({psel, continue_flag} !== 2'b01) begin
            miscompares++;
            $display("FAIL no_timeout_recover: psel/continue got %b expected 01", {psel, continue_flag});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait_states();
        test_slave_error();
        test_reset_mid_access();
        test_ignored_start();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
